// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART/ALU datapath: arbiter FSM state
// encoding and the byte width common to uart_tx, uart_rx and the arbiter.
package uart_alu_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      XFER = 1'b1
   } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and uart_tx-side byte streams plus arbiter status, bundled
// so the arbiter and its environment connect through one port each.
interface uart_tx_arbiter_if
   import uart_alu_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

   logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata;
   logic [NUM_REQ-1:0]            s_tvalid;
   logic [NUM_REQ-1:0]            s_tlast;
   logic [NUM_REQ-1:0]            s_tready;
   logic [DATA_WIDTH-1:0]         m_tdata;
   logic                          m_tvalid;
   logic                          m_tready;
   logic [NUM_REQ-1:0]            grant_o;
   logic                          busy_o;
   logic                          timeout_o;

   // Arbiter side: consumes requester streams and uart_tx ready.
   modport slave (
      input  s_tdata, s_tvalid, s_tlast, m_tready,
      output s_tready, m_tdata, m_tvalid, grant_o, busy_o, timeout_o
   );

   // Environment side: requesters plus uart_tx.
   modport master (
      output s_tdata, s_tvalid, s_tlast, m_tready,
      input  s_tready, m_tdata, m_tvalid, grant_o, busy_o, timeout_o
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority selector. Scans the request vector
// starting one above the last winner, wrapping, and returns the first hit as
// a one-hot vector and as an index.
module rr_pick
   import uart_alu_pkg::*;
#(
   parameter int N     = 2,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] last_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   localparam int SW = IDX_W + 1;

   logic [SW-1:0]    sum;
   logic [IDX_W-1:0] cand;

   // First requester at or after last_i+1, modulo N.
   always_comb begin
      // NOTE: every output and temporary gets a default before the loop, so no path can infer a latch.
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int off = 1; off <= N; off++) begin
         sum = {1'b0, last_i} + SW'(off);
         if (sum >= SW'(N)) begin
            sum = sum - SW'(N);
         end
         cand = sum[IDX_W-1:0];
         if (!any_o && req_i[cand]) begin
            any_o       = 1'b1;
            idx_o       = cand;
            gnt_o[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked arbiter sharing one uart_tx byte
// stream between NUM_REQ requesters. A grant lasts from a packet's first beat
// to its tlast beat or until MAX_PKT_LEN beats have passed. The output is a
// single registered byte that drains independently of the grant FSM.
module uart_tx_arbiter
   import uart_alu_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int MAX_PKT_LEN = 16
) (
   input  logic             clk,
   input  logic             rst,
   uart_tx_arbiter_if.slave bus
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);

   arb_state_t            state_q;
   logic [NUM_REQ-1:0]    grant_q;
   logic [IDX_W-1:0]      last_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [CNT_W-1:0]      cnt_d;
   logic [DATA_WIDTH-1:0] m_tdata_q;
   logic                  m_tvalid_q;
   logic                  timeout_q;

   logic [NUM_REQ-1:0]    pick_oh;
   logic [IDX_W-1:0]      pick_idx;
   logic                  pick_any;

   logic [DATA_WIDTH-1:0] sel_data;
   logic                  sel_valid;
   logic                  sel_last;
   logic                  out_ready;
   logic                  accept;

   rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req_i  (bus.s_tvalid),
      .last_i (last_q),
      .gnt_o  (pick_oh),
      .idx_o  (pick_idx),
      .any_o  (pick_any)
   );

   // One-hot mux of the granted requester's byte.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) begin
            sel_data = bus.s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign sel_valid = |(bus.s_tvalid & grant_q);
   assign sel_last  = |(bus.s_tlast & grant_q);
   // The output register can take a byte when empty or emptying this cycle.
   assign out_ready = !m_tvalid_q || bus.m_tready;
   assign accept    = (state_q == XFER) && out_ready && sel_valid;
   assign cnt_d     = cnt_q + CNT_W'(1);

   assign bus.s_tready  = (state_q == XFER && out_ready) ? grant_q : '0;
   assign bus.m_tdata   = m_tdata_q;
   assign bus.m_tvalid  = m_tvalid_q;
   assign bus.grant_o   = grant_q;
   assign bus.busy_o    = (state_q == XFER);
   assign bus.timeout_o = timeout_q;

   // Grant FSM, beat counter, watchdog pulse and output byte register.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      if (!rst) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         last_q     <= IDX_W'(NUM_REQ - 1);
         cnt_q      <= '0;
         // NOTE: the data register is reset too, since its value is visible on m_tdata.
         m_tdata_q  <= '0;
         m_tvalid_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         timeout_q <= 1'b0;

         if (accept) begin
            m_tdata_q  <= sel_data;
            m_tvalid_q <= 1'b1;
         end else if (bus.m_tready) begin
            m_tvalid_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (pick_any) begin
                  grant_q <= pick_oh;
                  last_q  <= pick_idx;
                  cnt_q   <= '0;
                  state_q <= XFER;
               end
            end
            XFER: begin
               if (accept) begin
                  cnt_q <= cnt_d;
                  if (sel_last) begin
                     grant_q <= '0;
                     state_q <= IDLE;
                  end else if (cnt_d == CNT_W'(MAX_PKT_LEN)) begin
                     grant_q   <= '0;
                     state_q   <= IDLE;
                     timeout_q <= 1'b1;
                  end
               end
            end
            default: begin
               grant_q <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter (2 requesters, 8-bit bytes,
// 4-beat watchdog). Per-requester byte queues model the sources, a log
// captures every byte uart_tx would take, and each test compares the log
// and sampled outputs against hand-computed values.
module tb_uart_tx_arbiter;

   localparam int NR  = 2;
   localparam int DW  = 8;
   localparam int MPL = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus_if ();

   uart_tx_arbiter #(
      .NUM_REQ     (NR),
      .DATA_WIDTH  (DW),
      .MAX_PKT_LEN (MPL)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int n_vec  = 0;
   int n_err  = 0;
   int cyc    = 0;
   int to_cnt = 0;

   logic [8:0] src0_q[$];
   logic [8:0] src1_q[$];
   logic [7:0] out_data[$];
   int         out_cyc[$];
   int         acc_cyc[$];

   logic       fire0, fire1, mfire;
   logic [7:0] mbyte;

   // Source and sink models: handshakes sampled mid-cycle, applied at the
   // edge, new source values driven 2 time units after the edge.
   initial begin
      bus_if.s_tvalid = '0;
      bus_if.s_tlast  = '0;
      bus_if.s_tdata  = '0;
      forever begin
         @(negedge clk);
         fire0 = rst && bus_if.s_tvalid[0] && bus_if.s_tready[0];
         fire1 = rst && bus_if.s_tvalid[1] && bus_if.s_tready[1];
         mfire = rst && bus_if.m_tvalid && bus_if.m_tready;
         mbyte = bus_if.m_tdata;
         if (bus_if.timeout_o === 1'b1) to_cnt++;
         @(posedge clk);
         cyc++;
         if (fire0 && src0_q.size() > 0) begin
            void'(src0_q.pop_front());
            acc_cyc.push_back(cyc);
         end
         if (fire1 && src1_q.size() > 0) begin
            void'(src1_q.pop_front());
            acc_cyc.push_back(cyc);
         end
         if (mfire) begin
            out_data.push_back(mbyte);
            out_cyc.push_back(cyc);
         end
         #2;
         if (src0_q.size() != 0) begin
            bus_if.s_tvalid[0]   = 1'b1;
            bus_if.s_tlast[0]    = src0_q[0][8];
            bus_if.s_tdata[7:0]  = src0_q[0][7:0];
         end else begin
            bus_if.s_tvalid[0]   = 1'b0;
            bus_if.s_tlast[0]    = 1'b0;
         end
         if (src1_q.size() != 0) begin
            bus_if.s_tvalid[1]   = 1'b1;
            bus_if.s_tlast[1]    = src1_q[0][8];
            bus_if.s_tdata[15:8] = src1_q[0][7:0];
         end else begin
            bus_if.s_tvalid[1]   = 1'b0;
            bus_if.s_tlast[1]    = 1'b0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      out_data.delete();
      out_cyc.delete();
      acc_cyc.delete();
      to_cnt = 0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      src0_q.delete();
      src1_q.delete();
      step();
      step();
      rst = 1'b1;
      clear_logs();
   endtask

   task automatic wait_empty(output bit ok);
      int b = 0;
      while ((src0_q.size() != 0 || src1_q.size() != 0) && b < 60) begin
         step();
         b++;
      end
      ok = (src0_q.size() == 0 && src1_q.size() == 0);
   endtask

   task automatic wait_acc(input int n, output bit ok);
      int b = 0;
      while (acc_cyc.size() < n && b < 60) begin
         step();
         b++;
      end
      ok = (acc_cyc.size() >= n);
   endtask

   function automatic logic [7:0] out_at(input int i);
      if (i < out_data.size()) return out_data[i];
      return 8'hxx;
   endfunction

   task automatic test_reset();
      logic [7:0] exp [2] = '{8'hA0, 8'hB0};
      bit ok;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus_if.m_tready = 1'b1;
      src0_q.push_back({1'b1, 8'hA0});
      src1_q.push_back({1'b1, 8'hB0});
      repeat (3) step();
      @(negedge clk);
      n_vec++; if (bus_if.grant_o !== 2'b00) begin $display("FAIL reset_grant: got %b expected 00", bus_if.grant_o); n_err++; end
      n_vec++; if (bus_if.s_tready !== 2'b00) begin $display("FAIL reset_s_tready: got %b expected 00", bus_if.s_tready); n_err++; end
      n_vec++; if (bus_if.m_tvalid !== 1'b0) begin $display("FAIL reset_m_tvalid: got %b expected 0", bus_if.m_tvalid); n_err++; end
      n_vec++; if (bus_if.m_tdata !== 8'h00) begin $display("FAIL reset_m_tdata: got %h expected 00", bus_if.m_tdata); n_err++; end
      n_vec++; if (bus_if.busy_o !== 1'b0) begin $display("FAIL reset_busy: got %b expected 0", bus_if.busy_o); n_err++; end
      n_vec++; if (bus_if.timeout_o !== 1'b0) begin $display("FAIL reset_timeout: got %b expected 0", bus_if.timeout_o); n_err++; end
      step();
      rst = 1'b1;
      clear_logs();
      @(negedge clk);
      n_vec++; if (bus_if.grant_o !== 2'b00) begin $display("FAIL rst_release_grant: got %b expected 00", bus_if.grant_o); n_err++; end
      step();
      @(negedge clk);
      n_vec++; if (bus_if.grant_o !== 2'b01) begin $display("FAIL first_grant: got %b expected 01", bus_if.grant_o); n_err++; end
      n_vec++; if (bus_if.s_tready !== 2'b01) begin $display("FAIL first_s_tready: got %b expected 01", bus_if.s_tready); n_err++; end
      wait_empty(ok);
      n_vec++; if (!ok) begin $display("FAIL reset_drain: sources not drained within budget"); n_err++; end
      repeat (3) step();
      n_vec++; if (out_data.size() != 2) begin $display("FAIL reset_out_count: got %0d expected 2", out_data.size()); n_err++; end
      for (int i = 0; i < 2; i++) begin
         n_vec++; if (out_at(i) !== exp[i]) begin $display("FAIL reset_out[%0d]: got %h expected %h", i, out_at(i), exp[i]); n_err++; end
      end
   endtask

   task automatic test_single_packet();
      logic [7:0] exp [3] = '{8'h41, 8'h42, 8'h43};
      bit ok;
      do_reset();
      src0_q.push_back({1'b0, 8'h41});
      src0_q.push_back({1'b0, 8'h42});
      src0_q.push_back({1'b1, 8'h43});
      wait_empty(ok);
      n_vec++; if (!ok) begin $display("FAIL single_drain: sources not drained within budget"); n_err++; end
      @(negedge clk);
      n_vec++; if (bus_if.grant_o !== 2'b00) begin $display("FAIL single_release_grant: got %b expected 00", bus_if.grant_o); n_err++; end
      n_vec++; if (bus_if.busy_o !== 1'b0) begin $display("FAIL single_release_busy: got %b expected 0", bus_if.busy_o); n_err++; end
      repeat (3) step();
      n_vec++; if (out_data.size() != 3) begin $display("FAIL single_out_count: got %0d expected 3", out_data.size()); n_err++; end
      for (int i = 0; i < 3; i++) begin
         n_vec++; if (out_at(i) !== exp[i]) begin $display("FAIL single_out[%0d]: got %h expected %h", i, out_at(i), exp[i]); n_err++; end
      end
      if (out_cyc.size() == 3 && acc_cyc.size() == 3) begin
         for (int i = 0; i < 3; i++) begin
            n_vec++; if (out_cyc[i] != acc_cyc[i] + 1) begin $display("FAIL single_latency[%0d]: out cycle %0d, expected %0d", i, out_cyc[i], acc_cyc[i] + 1); n_err++; end
         end
         for (int i = 0; i < 2; i++) begin
            n_vec++; if (acc_cyc[i+1] != acc_cyc[i] + 1) begin $display("FAIL single_rate[%0d]: accept cycle %0d, expected %0d", i, acc_cyc[i+1], acc_cyc[i] + 1); n_err++; end
         end
      end
   endtask

   task automatic test_round_robin();
      logic [7:0] exp [8] = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h10, 8'h11, 8'h20, 8'h21};
      bit ok;
      do_reset();
      for (int k = 0; k < 2; k++) begin
         src0_q.push_back({1'b0, 8'h10});
         src0_q.push_back({1'b1, 8'h11});
         src1_q.push_back({1'b0, 8'h20});
         src1_q.push_back({1'b1, 8'h21});
      end
      wait_empty(ok);
      n_vec++; if (!ok) begin $display("FAIL rr_drain: sources not drained within budget"); n_err++; end
      repeat (3) step();
      n_vec++; if (out_data.size() != 8) begin $display("FAIL rr_out_count: got %0d expected 8", out_data.size()); n_err++; end
      for (int i = 0; i < 8; i++) begin
         n_vec++; if (out_at(i) !== exp[i]) begin $display("FAIL rr_out[%0d]: got %h expected %h", i, out_at(i), exp[i]); n_err++; end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp [3] = '{8'h51, 8'h52, 8'h53};
      bit ok;
      do_reset();
      src0_q.push_back({1'b0, 8'h51});
      src0_q.push_back({1'b0, 8'h52});
      src0_q.push_back({1'b1, 8'h53});
      wait_acc(1, ok);
      n_vec++; if (!ok) begin $display("FAIL bp_first_accept: no accept within budget"); n_err++; end
      bus_if.m_tready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_vec++; if (bus_if.m_tvalid !== 1'b1) begin $display("FAIL bp_m_tvalid[%0d]: got %b expected 1", i, bus_if.m_tvalid); n_err++; end
         n_vec++; if (bus_if.m_tdata !== 8'h51) begin $display("FAIL bp_m_tdata[%0d]: got %h expected 51", i, bus_if.m_tdata); n_err++; end
         n_vec++; if (bus_if.s_tready !== 2'b00) begin $display("FAIL bp_s_tready[%0d]: got %b expected 00", i, bus_if.s_tready); n_err++; end
         step();
      end
      n_vec++; if (acc_cyc.size() != 1) begin $display("FAIL bp_stall_accepts: got %0d expected 1", acc_cyc.size()); n_err++; end
      bus_if.m_tready = 1'b1;
      wait_empty(ok);
      n_vec++; if (!ok) begin $display("FAIL bp_drain: sources not drained within budget"); n_err++; end
      repeat (3) step();
      n_vec++; if (out_data.size() != 3) begin $display("FAIL bp_out_count: got %0d expected 3", out_data.size()); n_err++; end
      for (int i = 0; i < 3; i++) begin
         n_vec++; if (out_at(i) !== exp[i]) begin $display("FAIL bp_out[%0d]: got %h expected %h", i, out_at(i), exp[i]); n_err++; end
      end
   endtask

   task automatic test_watchdog();
      logic [7:0] exp [7] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h02, 8'h65, 8'h66};
      bit ok;
      do_reset();
      // One-beat packet from req0 moves the pointer so req1 wins next.
      src0_q.push_back({1'b1, 8'h01});
      wait_empty(ok);
      n_vec++; if (!ok) begin $display("FAIL wd_prime_drain: one-beat packet not accepted"); n_err++; end
      repeat (2) step();
      n_vec++; if (out_at(0) !== 8'h01 || out_data.size() != 1) begin $display("FAIL wd_one_beat: got %h (count %0d) expected 01 (count 1)", out_at(0), out_data.size()); n_err++; end
      clear_logs();
      for (int i = 0; i < 6; i++) src1_q.push_back({1'b0, 8'h61 + 8'(i)});
      src0_q.push_back({1'b1, 8'h02});
      wait_acc(4, ok);
      n_vec++; if (!ok) begin $display("FAIL wd_accepts: 4 beats not accepted within budget"); n_err++; end
      @(negedge clk);
      n_vec++; if (bus_if.grant_o !== 2'b00) begin $display("FAIL wd_release_grant: got %b expected 00", bus_if.grant_o); n_err++; end
      n_vec++; if (bus_if.timeout_o !== 1'b1) begin $display("FAIL wd_timeout_pulse: got %b expected 1", bus_if.timeout_o); n_err++; end
      n_vec++; if (bus_if.busy_o !== 1'b0) begin $display("FAIL wd_release_busy: got %b expected 0", bus_if.busy_o); n_err++; end
      n_vec++; if (bus_if.m_tdata !== 8'h64 || bus_if.m_tvalid !== 1'b1) begin $display("FAIL wd_last_byte: got %h/%b expected 64/1", bus_if.m_tdata, bus_if.m_tvalid); n_err++; end
      step();
      @(negedge clk);
      n_vec++; if (bus_if.timeout_o !== 1'b0) begin $display("FAIL wd_timeout_width: got %b expected 0", bus_if.timeout_o); n_err++; end
      n_vec++; if (bus_if.grant_o !== 2'b01) begin $display("FAIL wd_next_grant: got %b expected 01", bus_if.grant_o); n_err++; end
      wait_empty(ok);
      n_vec++; if (!ok) begin $display("FAIL wd_drain: sources not drained within budget"); n_err++; end
      repeat (3) step();
      @(negedge clk);
      // req1 dropped tvalid without tlast: grant is held and it waits.
      n_vec++; if (bus_if.grant_o !== 2'b10) begin $display("FAIL wd_hold_grant: got %b expected 10", bus_if.grant_o); n_err++; end
      n_vec++; if (bus_if.s_tready !== 2'b10) begin $display("FAIL wd_hold_ready: got %b expected 10", bus_if.s_tready); n_err++; end
      n_vec++; if (to_cnt != 1) begin $display("FAIL wd_timeout_count: got %0d expected 1", to_cnt); n_err++; end
      n_vec++; if (out_data.size() != 7) begin $display("FAIL wd_out_count: got %0d expected 7", out_data.size()); n_err++; end
      for (int i = 0; i < 7; i++) begin
         n_vec++; if (out_at(i) !== exp[i]) begin $display("FAIL wd_out[%0d]: got %h expected %h", i, out_at(i), exp[i]); n_err++; end
      end
   endtask

   task automatic test_reset_mid_packet();
      logic [7:0] exp [3] = '{8'h71, 8'h91, 8'h81};
      bit ok;
      do_reset();
      for (int i = 0; i < 5; i++) src0_q.push_back({(i == 4), 8'h71 + 8'(i)});
      wait_acc(2, ok);
      n_vec++; if (!ok) begin $display("FAIL mid_accepts: 2 beats not accepted within budget"); n_err++; end
      rst = 1'b0;
      src0_q.delete();
      step();
      @(negedge clk);
      n_vec++; if (bus_if.m_tvalid !== 1'b0) begin $display("FAIL mid_m_tvalid: got %b expected 0", bus_if.m_tvalid); n_err++; end
      n_vec++; if (bus_if.grant_o !== 2'b00) begin $display("FAIL mid_grant: got %b expected 00", bus_if.grant_o); n_err++; end
      n_vec++; if (bus_if.s_tready !== 2'b00) begin $display("FAIL mid_s_tready: got %b expected 00", bus_if.s_tready); n_err++; end
      step();
      src0_q.push_back({1'b1, 8'h91});
      src1_q.push_back({1'b1, 8'h81});
      step();
      rst = 1'b1;
      step();
      @(negedge clk);
      n_vec++; if (bus_if.grant_o !== 2'b01) begin $display("FAIL mid_restart_grant: got %b expected 01", bus_if.grant_o); n_err++; end
      wait_empty(ok);
      n_vec++; if (!ok) begin $display("FAIL mid_drain: sources not drained within budget"); n_err++; end
      repeat (3) step();
      n_vec++; if (out_data.size() != 3) begin $display("FAIL mid_out_count: got %0d expected 3", out_data.size()); n_err++; end
      for (int i = 0; i < 3; i++) begin
         n_vec++; if (out_at(i) !== exp[i]) begin $display("FAIL mid_out[%0d]: got %h expected %h", i, out_at(i), exp[i]); n_err++; end
      end
   endtask

   initial begin
      rst = 1'b0;
      bus_if.m_tready = 1'b1;
      test_reset();
      test_single_packet();
      test_round_robin();
      test_backpressure();
      test_watchdog();
      test_reset_mid_packet();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish within 200000 time units");
      $fatal(1, "global timeout");
   end

endmodule
